nx_fifo_thresh: RTL

NX_FIFO_THRESH -- requirements
Module: nx_fifo_thresh

---
 rtl/nx_fifo_thresh.sv | 105 ++++++++++
 1 files changed

// File: rtl/nx_fifo_thresh.sv
// Synchronous single-clock FIFO with first-word fall-through read data,
// threshold flags, occupancy/vacancy counts, high-water mark and error pulses.
module nx_fifo_thresh #(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 64,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 1,
   parameter int DATA_RESET = 1,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic             ren,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic             underflow,
   output logic             overflow,
   output logic [CW-1:0]    used_slots,
   output logic [CW-1:0]    free_slots,
   output logic [CW-1:0]    hwm
);

   localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] LP_DEPTH  = CW'(DEPTH);
   localparam logic [CW-1:0] LP_AFULL  = CW'(AFULL_LVL);
   localparam logic [CW-1:0] LP_AEMPTY = CW'(AEMPTY_LVL);
   localparam logic [AW-1:0] LP_LAST   = AW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_used;
   logic [CW-1:0]    r_hwm;
   logic             r_ovf;
   logic             r_unf;

   logic             w_empty;
   logic             w_full;
   logic             w_wr;
   logic             w_rd;
   logic [CW-1:0]    w_used_nxt;

   assign w_empty = (r_used == '0);
   assign w_full  = (r_used == LP_DEPTH);
   // clear overrides both requests so a flush never moves data or raises errors
   assign w_wr    = wen && !w_full  && !clear;
   assign w_rd    = ren && !w_empty && !clear;

   always_comb begin
      w_used_nxt = r_used;
      case ({w_wr, w_rd})
         2'b10:   w_used_nxt = r_used + 1'b1;
         2'b01:   w_used_nxt = r_used - 1'b1;
         default: w_used_nxt = r_used;
      endcase
   end

   // Storage is deliberately never reset; empty masking hides stale entries.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_used <= '0;
         r_hwm  <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else if (clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_used <= '0;
         r_hwm  <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= (r_wptr == LP_LAST) ? '0 : r_wptr + 1'b1;
         if (w_rd) r_rptr <= (r_rptr == LP_LAST) ? '0 : r_rptr + 1'b1;
         r_used <= w_used_nxt;
         if (w_used_nxt > r_hwm) r_hwm <= w_used_nxt;
         r_ovf  <= wen && w_full;
         r_unf  <= ren && w_empty;
      end
   end

   assign rdata        = ((DATA_RESET != 0) && w_empty) ? '0 : r_mem[r_rptr];
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_full  = (r_used >= LP_AFULL);
   assign almost_empty = (r_used <= LP_AEMPTY);
   assign used_slots   = r_used;
   assign free_slots   = LP_DEPTH - r_used;
   assign hwm          = r_hwm;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule
